job_dispatcher: RTL and testbench
=================================

// Module: job_dispatcher
// PURPOSE
//   Upstream stage for the single-job worker FSM (start/busy/done pulse protocol).
//   Accepts job requests on a valid/ready handshake and queues up to MAX_PENDING of them.
//   Issues one start pulse per job and waits for the worker's done pulse before launching the next.
//   Counts completed jobs; an optional watchdog aborts a hung job.
// PARAMETERS
//   MAX_PENDING     4    max queued (accepted, not yet launched) jobs; >= 1
//   TIMEOUT_CYCLES  32   WAIT-state cycles without done before abort; >= 2 (watchdog only)
//   CNT_W           16   width of done_count_o
// PORTS
//   clk_i           in   1      single clock, all logic posedge
//   rst_i           in   1      reset, asynchronous, active-high; clears all state
//   req_valid_i     in   1      job request
//   req_ready_o     out  1      dispatcher can accept; handshake = req_valid_i & req_ready_o
//   worker_start_o  out  1      one-cycle start pulse to worker
//   worker_busy_i   in   1      worker busy (status only, never gates transitions)
//   worker_done_i   in   1      worker one-cycle done pulse
//   pending_o       out  PW     queued job count, PW = $clog2(MAX_PENDING+1)
//   done_count_o    out  CNT_W  completed jobs, wraps modulo 2**CNT_W
//   timeout_o       out  1      one-cycle pulse on watchdog abort
//   idle_o          out  1      1 when state is S_IDLE and pending_o == 0
// BEHAVIOUR
//   Reset values
//   - state S_IDLE; pending 0; done_count 0; timeout counter 0.
//   - worker_start_o 0, timeout_o 0, req_ready_o 1, idle_o 1.
//   Handshake
//   - req_ready_o = (pending_q < MAX_PENDING); combinational from registers only.
//   - A request is accepted only on the handshake; pending increments on the following edge.
//   FSM states (2-bit enum)
//   - S_IDLE:  if pending_q != 0, go to S_START and decrement pending.
//   - S_START: worker_start_o = 1 (Moore, exactly 1 cycle); go to S_WAIT; clear timeout counter.
//   - S_WAIT:  on worker_done_i, increment done_count.
//              If pending_q != 0, go directly to S_START and decrement pending; else go to S_IDLE.
//   - Unreachable encoding: go to S_IDLE.
//   Simultaneous events and edge cases
//   - Accept and launch-decrement in the same cycle: pending unchanged.
//   - Pending never exceeds MAX_PENDING and never underflows.
//   - worker_done_i outside S_WAIT is ignored and not counted.
//   - Back-to-back jobs: start pulses spaced (worker latency + 2) cycles; worker WAIT_CYCLES=5 gives 7.
//   - done_count 2**CNT_W-1 + 1 wraps to 0, with no flag.
//   - rst_i mid-job: immediately returns to reset values; queued jobs are discarded.
//     The worker is assumed to be reset together with the dispatcher.
// CONFIGURATION
//   DISPATCH_TIMEOUT_EN defined
//   - In S_WAIT, a counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle without done.
//   - When it reaches TIMEOUT_CYCLES-1 with no done:
//     pulse timeout_o for 1 cycle, drop the job (no done_count increment),
//     go to S_START if pending != 0, else S_IDLE.
//   - done arriving on the final cycle wins: it counts as completed, with no timeout.
//   DISPATCH_TIMEOUT_EN undefined
//   - No counter; timeout_o tied 0; S_WAIT waits indefinitely.
// TESTING  (MAX_PENDING=4, TIMEOUT_CYCLES=32, real worker with WAIT_CYCLES=5 unless noted)
//   1 Reset: rst_i high mid-S_WAIT with pending=3
//     -> next cycle pending_o=0, done_count_o=0, start=0, req_ready_o=1, idle_o=1.
//   2 Single job: valid 1 cycle at c0
//     -> pending_o=1 @c1; worker_start_o @c2 only; done @c8; done_count_o=1 and idle_o=1 @c9.
//   3 Fill: worker stub never sends done; valid held for 8 cycles
//     -> 5 accepted (1 launched + 4 queued); req_ready_o=0 with pending_o=4; no further start pulses.
//   4 Accept+launch collision: pending=1 in S_WAIT, done and request in the same cycle
//     -> S_START next cycle; pending_o stays 1.
//   5 Back-to-back: 3 requests c0..c2
//     -> start pulses at c2, c9, c16; done_count_o=3 after last done; idle_o=1.
//   6 Watchdog (macro defined): stub never sends done
//     -> timeout_o pulses once, 32 cycles after the start pulse; done_count_o unchanged; next job launches.
//     Macro undefined: timeout_o stays 0 for 100 cycles.

Source files
------------

// File: rtl/job_dispatcher.sv
// Purpose : queues job requests and launches them one at a time on a start/busy/done worker.
// Latency : accepted request counts in pending_o next cycle; start pulse one cycle after that
//           when idle; next start follows the worker's done pulse by one cycle.
// Backpressure: req_ready_o drops while MAX_PENDING jobs are queued (registered-only path).
//
// Ports:
//   clk_i, rst_i            clock; asynchronous active-high reset
//   req_valid_i/req_ready_o job request handshake
//   worker_start_o          one-cycle start pulse to the worker
//   worker_busy_i           worker status, observation only
//   worker_done_i           one-cycle done pulse from the worker
//   pending_o               queued (accepted, not yet launched) job count
//   done_count_o            completed jobs, wraps silently
//   timeout_o               one-cycle pulse when the watchdog aborts a job
//   idle_o                  no job running and nothing queued
//
// Optional feature: define DISPATCH_TIMEOUT_EN to enable the WAIT-state watchdog.
module job_dispatcher #(
    parameter int MAX_PENDING    = 4,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 16,
    localparam int PW            = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic             worker_start_o,
    input  logic             worker_busy_i,
    input  logic             worker_done_i,
    output logic [PW-1:0]    pending_o,
    output logic [CNT_W-1:0] done_count_o,
    output logic             timeout_o,
    output logic             idle_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);

    state_t             state_q, state_d;
    logic [PW-1:0]      pending_q, pending_d;
    logic [CNT_W-1:0]   done_count_q, done_count_d;

    logic               accept;
    logic               launch;     // pops one queued job into S_START
    logic               job_done;   // done accepted in S_WAIT
    logic               job_tmo;    // watchdog abort in S_WAIT
    logic               wd_expire;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          unused_busy;

    assign unused_busy = worker_busy_i;
    assign wd_expire   = (tmo_cnt_q == TMO_LAST);

    // Cleared while the start pulse is out, counts every WAIT cycle without done.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_START) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_WAIT && !worker_done_i && !wd_expire) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{worker_busy_i, 32'(TIMEOUT_CYCLES)};
    assign wd_expire  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            done_count_q <= done_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        job_done = 1'b0;
        job_tmo  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    launch  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the watchdog's last cycle still counts as completion.
                if (worker_done_i) begin
                    job_done = 1'b1;
                end else if (wd_expire) begin
                    job_tmo = 1'b1;
                end
                if (job_done || job_tmo) begin
                    if (pending_q != '0) begin
                        launch  = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Queue depth and completion counter; accept and launch together leave pending unchanged.
    always_comb begin
        accept       = req_valid_i & req_ready_o;
        pending_d    = pending_q + PW'(accept) - PW'(launch);
        done_count_d = done_count_q + CNT_W'(job_done);
    end

    // Outputs
    always_comb begin
        req_ready_o    = (pending_q < MAX_P);
        worker_start_o = (state_q == S_START);
        idle_o         = (state_q == S_IDLE) && (pending_q == '0);
        timeout_o      = job_tmo;
        pending_o      = pending_q;
        done_count_o   = done_count_q;
    end

endmodule

// File: tb/tb_job_dispatcher.sv
// Purpose : self-checking bench for job_dispatcher with a behavioural worker (done 6 cycles after start).
// Latency : expected start/timeout cycles and status snapshots are queued by stimulus, checked by a monitor.
// Backpressure: fill scenarios hold req_valid and expect req_ready to drop at MAX_PENDING.
module tb_job_dispatcher;

    localparam int MAXP = 4;
    localparam int TMO  = 32;
    localparam int CW   = 3;    // small counter so the wrap is reachable
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          worker_start;
    logic          worker_busy;
    logic          worker_done;
    logic [PW-1:0] pending;
    logic [CW-1:0] done_count;
    logic          timeout;
    logic          idle;

    always #5 clk = ~clk;

    job_dispatcher #(
        .MAX_PENDING   (MAXP),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .worker_start_o(worker_start),
        .worker_busy_i (worker_busy),
        .worker_done_i (worker_done),
        .pending_o     (pending),
        .done_count_o  (done_count),
        .timeout_o     (timeout),
        .idle_o        (idle)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        int pend;
        int dc;
        int rdy;
        int idl;
    } chk_t;

    chk_t chk_q[$];
    int   start_q[$];
    int   tmo_q[$];
    int   t0;

    // Worker model: done pulse 6 cycles after the start pulse (WAIT_CYCLES=5) when real.
    bit wk_real;
    bit force_done;
    int wk_cd;
    bit wk_done;

    assign worker_done = wk_done | force_done;
    assign worker_busy = (wk_cd != 0);

    initial begin
        wk_cd   = 0;
        wk_done = 0;
        forever begin
            @(posedge clk);
            #1;
            wk_done = 0;
            if (rst) begin
                wk_cd = 0;
            end else begin
                if (wk_cd != 0) begin
                    wk_cd--;
                    wk_done = (wk_cd == 0);
                end
                if (worker_start && wk_real) wk_cd = 6;
            end
        end
    end

    function automatic void cmp(string name, int c, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, got, exp);
        end
    endfunction

    // Monitor / scoreboard
    chk_t c_m;
    int   e_m;
    always @(negedge clk) begin
        if (worker_start) begin
            if (start_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL start_pulse unexpected cyc=%0d got=1 exp=0", cyc);
            end else begin
                e_m = start_q.pop_front();
                cmp("start_cycle", cyc, cyc, e_m);
            end
        end
        if (timeout) begin
            if (tmo_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout_pulse unexpected cyc=%0d got=1 exp=0", cyc);
            end else begin
                e_m = tmo_q.pop_front();
                cmp("timeout_cycle", cyc, cyc, e_m);
            end
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c_m = chk_q.pop_front();
            if (c_m.cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL snapshot_missed cyc=%0d got=%0d exp=%0d", cyc, cyc, c_m.cyc);
            end else begin
                cmp("pending", cyc, int'(pending), c_m.pend);
                cmp("done_count", cyc, int'(done_count), c_m.dc);
                cmp("req_ready", cyc, int'(req_ready), c_m.rdy);
                cmp("idle", cyc, int'(idle), c_m.idl);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_snap(int off, int p, int dc, int r, int i);
        chk_t c;
        c.cyc  = t0 + off;
        c.pend = p;
        c.dc   = dc;
        c.rdy  = r;
        c.idl  = i;
        chk_q.push_back(c);
    endtask

    task automatic exp_start(int off);
        start_q.push_back(t0 + off);
    endtask

    task automatic exp_tmo(int off);
        tmo_q.push_back(t0 + off);
    endtask

    // Drives req_valid from bit k of mask in cycle t0+k, for n cycles.
    task automatic run_valid(int n, logic [63:0] mask);
        for (int k = 0; k < n; k++) begin
            req_valid = (k < 64) ? mask[k] : 1'b0;
            step();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        force_done = 1'b0;
        wk_real    = 1'b1;
        step();
        step();

        // Reset state
        t0 = cyc;
        exp_snap(0, 0, 0, 1, 1);
        step();
        rst = 1'b0;
        step();
        step();

        // Single job
        t0 = cyc;
        exp_snap(1, 1, 0, 1, 0);
        exp_snap(2, 0, 0, 1, 0);
        exp_start(2);
        exp_snap(8, 0, 0, 1, 0);
        exp_snap(9, 0, 1, 1, 1);
        run_valid(12, 64'h1);

        // Back-to-back, three requests
        t0 = cyc;
        exp_start(2);
        exp_snap(3, 2, 1, 1, 0);
        exp_snap(9, 1, 2, 1, 0);
        exp_start(9);
        exp_snap(16, 0, 3, 1, 0);
        exp_start(16);
        exp_snap(23, 0, 4, 1, 1);
        run_valid(26, 64'h7);

        // Reset mid-WAIT with three queued jobs, worker never finishes
        wk_real = 1'b0;
        t0 = cyc;
        exp_start(2);
        exp_snap(4, 3, 4, 1, 0);
        exp_snap(5, 0, 0, 1, 1);
        exp_snap(8, 0, 0, 1, 1);
        run_valid(5, 64'hf);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();

        // Accept and launch in the same cycle as done
        wk_real = 1'b1;
        t0 = cyc;
        exp_start(2);
        exp_snap(8, 1, 0, 1, 0);
        exp_snap(9, 1, 1, 1, 0);
        exp_start(9);
        exp_snap(10, 1, 1, 1, 0);
        exp_snap(16, 0, 2, 1, 0);
        exp_start(16);
        exp_snap(23, 0, 3, 1, 1);
        run_valid(26, 64'h103);

        // Done pulse while idle is ignored
        t0 = cyc;
        exp_snap(1, 0, 3, 1, 1);
        exp_snap(2, 0, 3, 1, 1);
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        step();
        step();
        step();

        // Five jobs: queue fills with a real worker, done counter wraps 7 -> 0
        t0 = cyc;
        exp_start(2);
        exp_snap(5, 4, 3, 0, 0);
        exp_snap(9, 3, 4, 1, 0);
        exp_start(9);
        exp_snap(16, 2, 5, 1, 0);
        exp_start(16);
        exp_snap(23, 1, 6, 1, 0);
        exp_start(23);
        exp_snap(30, 0, 7, 1, 0);
        exp_start(30);
        exp_snap(37, 0, 0, 1, 1);
        run_valid(40, 64'h1f);

        // Fill with a hung worker; watchdog behaviour depends on build
        wk_real = 1'b0;
        t0 = cyc;
        exp_start(2);
        exp_snap(5, 4, 0, 0, 0);
        exp_snap(8, 4, 0, 0, 0);
`ifdef DISPATCH_TIMEOUT_EN
        exp_tmo(34);
        exp_snap(35, 3, 0, 1, 0);
        exp_start(35);
        exp_tmo(67);
        exp_start(68);
        exp_tmo(100);
        exp_start(101);
        exp_tmo(133);
        exp_start(134);
        exp_tmo(166);
        exp_snap(167, 0, 0, 1, 1);
        run_valid(175, 64'hff);
`else
        exp_snap(108, 4, 0, 0, 0);
        run_valid(112, 64'hff);
`endif

        step();
        step();
        cmp("leftover_expected", cyc, chk_q.size() + start_q.size() + tmo_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
